// File: rtl/time_display_scan_if.sv
// Purpose : bundles the time inputs and the multiplexed 7-segment outputs of time_display_scan.
// Ports   : hour/minute/second (BCD bytes) and blank_en come from the time source.
//           an/seg/dp/frame_done go to the display pins. The master modport is the time source and display side.
//           The slave modport is the scan block.
interface time_display_scan_if;
   logic [7:0] hour;        // BCD hours   [7:4] tens, [3:0] ones
   logic [7:0] minute;      // BCD minutes [7:4] tens, [3:0] ones
   logic [7:0] second;      // BCD seconds [7:4] tens, [3:0] ones
   logic       blank_en;    // suppress a zero hour-tens digit
   logic [5:0] an;          // digit enables, active-low, an[0] = rightmost
   logic [6:0] seg;         // segments gfedcba, active-low
   logic       dp;          // decimal point, active-low
   logic       frame_done;  // one-cycle pulse per frame wrap

   modport master (
      output hour, minute, second, blank_en,
      input  an, seg, dp, frame_done
   );

   modport slave (
      input  hour, minute, second, blank_en,
      output an, seg, dp, frame_done
   );
endinterface

// File: rtl/time_display_scan.sv
// Purpose : scans a BCD hh:mm:ss value onto a 6-digit common-anode 7-segment display, one digit per SCAN_DIV clocks.
// Latency : outputs update 1 clk after each scan tick. The time snapshot is taken once per frame, at the 5->0 wrap.
// Backpr. : none. Inputs are sampled freely, and the display side cannot stall the scan.
// Ports   : clk and reset are plain ports. The reset is synchronous and active-high. bus is the time_display_scan_if.slave modport.
module time_display_scan #(
   parameter int SCAN_DIV = 50000   // clk cycles each digit is held, >= 2
) (
   input  logic                 clk,
   input  logic                 reset,
   time_display_scan_if.slave   bus
);

   localparam int            PW      = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] PS_LAST = PW'(SCAN_DIV - 1);

   logic [PW-1:0] ps_q;
   logic [2:0]    idx_q;
   logic [7:0]    h_q, m_q, s_q;
   logic [5:0]    an_q;
   logic [6:0]    seg_q;
   logic          dp_q;
   logic          fd_q;

   logic          tick;
   logic          wrap;
   logic [2:0]    idx_nxt;
   logic [7:0]    s_eff;
   logic [3:0]    nib;
   logic [6:0]    font;
   logic [5:0]    an_nxt;
   logic [6:0]    seg_nxt;
   logic          dp_nxt;

   always_comb begin
      tick    = (ps_q == PS_LAST);
      wrap    = tick && (idx_q == 3'd5);
      idx_nxt = wrap ? 3'd0 : idx_q + 3'd1;

      // On the wrap edge, digit 0 must show the value being captured this cycle.
      // It must not show the stale snapshot, so the live second byte is used.
      s_eff = wrap ? bus.second : s_q;

      case (idx_nxt)
         3'd0:    nib = s_eff[3:0];
         3'd1:    nib = s_eff[7:4];
         3'd2:    nib = m_q[3:0];
         3'd3:    nib = m_q[7:4];
         3'd4:    nib = h_q[3:0];
         default: nib = h_q[7:4];
      endcase

      case (nib)
         4'd0:    font = 7'h3F;
         4'd1:    font = 7'h06;
         4'd2:    font = 7'h5B;
         4'd3:    font = 7'h4F;
         4'd4:    font = 7'h66;
         4'd5:    font = 7'h6D;
         4'd6:    font = 7'h7D;
         4'd7:    font = 7'h07;
         4'd8:    font = 7'h7F;
         4'd9:    font = 7'h6F;
         default: font = 7'h00;   // non-BCD nibble shows a dark digit, and its anode stays on
      endcase

      an_nxt  = ~(6'b000001 << idx_nxt);
      seg_nxt = ~font;
      // The separator points sit after the minute-ones and hour-ones digits. They light on even seconds.
      dp_nxt  = ~(((idx_nxt == 3'd2) || (idx_nxt == 3'd4)) && !s_eff[0]);

      // Leading hour zero is blanked entirely. blank_en is taken live, not from the snapshot.
      if ((idx_nxt == 3'd5) && bus.blank_en && (h_q[7:4] == 4'd0)) begin
         an_nxt  = 6'b111111;
         seg_nxt = 7'b1111111;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ps_q  <= '0;
         idx_q <= 3'd0;
         h_q   <= 8'h00;
         m_q   <= 8'h00;
         s_q   <= 8'h00;
         an_q  <= 6'b111111;
         seg_q <= 7'b1111111;
         dp_q  <= 1'b1;
         fd_q  <= 1'b0;
      end else begin
         fd_q <= wrap;
         ps_q <= tick ? '0 : ps_q + PW'(1);
         if (tick) begin
            idx_q <= idx_nxt;
            an_q  <= an_nxt;
            seg_q <= seg_nxt;
            dp_q  <= dp_nxt;
         end
         if (wrap) begin
            h_q <= bus.hour;
            m_q <= bus.minute;
            s_q <= bus.second;
         end
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.dp         = dp_q;
   assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_time_display_scan.sv
// Purpose : self-checking bench for time_display_scan. It runs directed steps followed by a randomized phase.
// Model   : expected outputs are derived from the edge count since reset, using tick = every SD-th edge and digit = (tick number) mod 6.
// Ports   : drives the interface master side and checks all outputs 1 time unit after every rising edge.
module tb_time_display_scan;
   localparam int SD = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   time_display_scan_if tif();

   time_display_scan #(.SCAN_DIV(SD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (tif)
   );

   int checks = 0;
   int errors = 0;

   // reference model state
   int         cnt;
   logic [7:0] sh, sm, ss;
   logic [5:0] e_an;
   logic [6:0] e_seg;
   logic       e_dp;
   logic       e_fd;
   logic [6:0] font_tab [10];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h (t=%0t cnt=%0d)", tag, obs, exp, $time, cnt);
      end
   endtask

   task automatic model_edge();
      int d, sel, v;
      if (reset) begin
         cnt   = 0;
         sh    = 8'h00;
         sm    = 8'h00;
         ss    = 8'h00;
         e_an  = 6'h3F;
         e_seg = 7'h7F;
         e_dp  = 1'b1;
         e_fd  = 1'b0;
      end else begin
         cnt++;
         e_fd = 1'b0;
         if (cnt % SD == 0) begin
            d = (cnt / SD) % 6;
            if (d == 0) begin
               sh   = tif.hour;
               sm   = tif.minute;
               ss   = tif.second;
               e_fd = 1'b1;
            end
            sel   = (d < 2) ? int'(ss) : (d < 4) ? int'(sm) : int'(sh);
            v     = (d % 2 == 1) ? sel / 16 : sel % 16;
            e_seg = (v < 10) ? ~font_tab[v] : 7'h7F;
            for (int i = 0; i < 6; i++) e_an[i] = (i != d);
            e_dp  = ((d == 2 || d == 4) && (ss % 2 == 0)) ? 1'b0 : 1'b1;
            if (d == 5 && tif.blank_en && (sh / 16 == 0)) begin
               e_an  = 6'h3F;
               e_seg = 7'h7F;
            end
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      model_edge();
      chk("model_an",  {26'd0, tif.an},         {26'd0, e_an});
      chk("model_seg", {25'd0, tif.seg},        {25'd0, e_seg});
      chk("model_dp",  {31'd0, tif.dp},         {31'd0, e_dp});
      chk("model_fd",  {31'd0, tif.frame_done}, {31'd0, e_fd});
   endtask

   task automatic run_to(input int target);
      int guard;
      guard = 0;
      while (cnt != target && guard < 2000) begin
         cyc();
         guard++;
      end
      if (cnt != target) begin
         errors++;
         $error("FAIL run_to timeout observed=%0d expected=%0d", cnt, target);
      end
   endtask

   initial begin
      font_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      cnt = 0;
      reset        = 1'b1;
      tif.hour     = 8'h12;
      tif.minute   = 8'h34;
      tif.second   = 8'h56;
      tif.blank_en = 1'b0;

      // reset held two cycles
      cyc();
      cyc();
      chk("rst_an",  {26'd0, tif.an},         32'h3F);
      chk("rst_seg", {25'd0, tif.seg},        32'h7F);
      chk("rst_dp",  {31'd0, tif.dp},         32'h1);
      chk("rst_fd",  {31'd0, tif.frame_done}, 32'h0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("pre_tick_an",  {26'd0, tif.an},  32'h3F);
         chk("pre_tick_seg", {25'd0, tif.seg}, 32'h7F);
         chk("pre_tick_dp",  {31'd0, tif.dp},  32'h1);
      end
      cyc();
      chk("first_tick_an",  {26'd0, tif.an},  {26'd0, 6'b111101});
      chk("first_tick_seg", {25'd0, tif.seg}, {25'd0, 7'b1000000});

      // first wrap captures 12:34:56
      run_to(24);
      chk("wrap_fd",  {31'd0, tif.frame_done}, 32'h1);
      chk("wrap_an",  {26'd0, tif.an},         {26'd0, 6'b111110});
      chk("wrap_seg", {25'd0, tif.seg},        {25'd0, 7'b0000010});
      cyc();
      chk("wrap_fd_pulse", {31'd0, tif.frame_done}, 32'h0);
      run_to(28);
      chk("d1_seg", {25'd0, tif.seg}, {25'd0, 7'b0010010});
      run_to(32);
      chk("d2_seg", {25'd0, tif.seg}, {25'd0, 7'b0011001});
      chk("d2_an",  {26'd0, tif.an},  {26'd0, 6'b111011});
      chk("d2_dp",  {31'd0, tif.dp},  32'h0);

      // mid-frame change is invisible until the next wrap
      tif.second = 8'h57;
      run_to(36);
      chk("d3_old_seg", {25'd0, tif.seg}, {25'd0, 7'b0110000});
      run_to(40);
      chk("d4_old_seg", {25'd0, tif.seg}, {25'd0, 7'b0100100});
      chk("d4_old_dp",  {31'd0, tif.dp},  32'h0);
      run_to(44);
      chk("d5_old_seg", {25'd0, tif.seg}, {25'd0, 7'b1111001});
      run_to(48);
      chk("wrap2_seg", {25'd0, tif.seg},        {25'd0, 7'b1111000});
      chk("wrap2_fd",  {31'd0, tif.frame_done}, 32'h1);
      run_to(56);
      chk("odd_d2_dp", {31'd0, tif.dp}, 32'h1);
      run_to(64);
      chk("odd_d4_dp", {31'd0, tif.dp}, 32'h1);

      // leading-zero blanking, then blank_en dropped live
      tif.hour     = 8'h09;
      tif.blank_en = 1'b1;
      run_to(92);
      chk("blank_an",  {26'd0, tif.an},  32'h3F);
      chk("blank_seg", {25'd0, tif.seg}, 32'h7F);
      tif.blank_en = 1'b0;
      run_to(116);
      chk("noblank_an",  {26'd0, tif.an},  {26'd0, 6'b011111});
      chk("noblank_seg", {25'd0, tif.seg}, {25'd0, 7'b1000000});

      // invalid BCD nibble
      tif.minute = 8'h3A;
      run_to(128);
      chk("inv_an",  {26'd0, tif.an},  {26'd0, 6'b111011});
      chk("inv_seg", {25'd0, tif.seg}, 32'h7F);

      // one-cycle reset while idx=3 and prescaler mid-count
      run_to(133);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("mid_rst_an",  {26'd0, tif.an},         32'h3F);
      chk("mid_rst_seg", {25'd0, tif.seg},        32'h7F);
      chk("mid_rst_dp",  {31'd0, tif.dp},         32'h1);
      chk("mid_rst_fd",  {31'd0, tif.frame_done}, 32'h0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("mid_rst_hold_an", {26'd0, tif.an}, 32'h3F);
      end
      cyc();
      chk("mid_rst_tick_an", {26'd0, tif.an}, {26'd0, 6'b111101});

      // randomized phase against the model
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            tif.hour   = 8'($urandom_range(0, 255));
            tif.minute = 8'($urandom_range(0, 255));
            tif.second = 8'($urandom_range(0, 255));
         end
         if ($urandom_range(0, 15) == 0) tif.blank_en = ~tif.blank_en;
         reset = ($urandom_range(0, 199) == 0);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/time_display_scan.md
Name: time_display_scan

Overview:
- Downstream consumer of the clock counter stage. Takes the BCD hour, minute and second bytes and drives a 6-digit multiplexed common-anode 7-segment display.
- Time-multiplexes one digit at a time at a parameterised scan rate.
- Snapshots the time once per frame so no frame shows a torn time value.
- Blinks the separator decimal points on even seconds; optionally blanks a leading hour zero.

Parameters:
- SCAN_DIV, 50000, clk cycles each digit is held; minimum 2; prescaler width = clog2(SCAN_DIV).

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- hour  input  8  BCD hours; [7:4] tens, [3:0] ones.
- minute  input  8  BCD minutes; [7:4] tens, [3:0] ones.
- second  input  8  BCD seconds; [7:4] tens, [3:0] ones.
- blank_en  input  1  when 1, suppress a zero hour-tens digit.
- an  output  6  digit enables, active-low; an[0] is the rightmost digit.
- seg  output  7  segments, active-low; seg[6:0] = g,f,e,d,c,b,a.
- dp  output  1  decimal point, active-low.
- frame_done  output  1  one-cycle pulse on each frame wrap.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high. All state is updated on the rising edge of clk only.
- Reset values:
  - prescaler = 0, idx = 0, snapshot registers (h, m, s) = 0x00.
  - an = 6'b111111, seg = 7'b1111111, dp = 1, frame_done = 0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - tick = (prescaler == SCAN_DIV-1).
- Digit index:
  - On a tick edge, idx advances 0→1→2→3→4→5→0. Otherwise idx holds.
- Digit map:
  - 0 = s[3:0], 1 = s[7:4]
  - 2 = m[3:0], 3 = m[7:4]
  - 4 = h[3:0], 5 = h[7:4]
- Snapshot:
  - On the tick edge where idx wraps 5→0, h/m/s load hour/minute/second and frame_done = 1 for that one cycle.
  - Input changes at any other time are not visible until the next wrap.
- Output registers:
  - an, seg and dp are registered and load on every tick edge, using the new idx.
  - On the wrap edge, digit 0 is decoded from the input values being captured, not the old snapshot.
  - Between ticks, an, seg and dp hold.
  - Display latency is exactly 1 clk after the tick cycle.
- an: only bit [new idx] is driven low; all other bits are high.
- Decoder (active-high gfedcba, before inversion onto seg):
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66
  - 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F
  - Nibble 0xA-0xF → all segments off (seg = 7'b1111111); the digit's an stays active.
- dp:
  - 0 (lit) only on digits 2 and 4, and only when the relevant s[0] == 0 (even second).
  - For digit 0 on the wrap edge, the relevant s[0] is the newly captured second[0]; otherwise it is the snapshot s[0].
  - dp = 1 on every other digit.
- Leading-zero blank:
  - Applies when idx becomes 5, blank_en = 1 and h[7:4] == 0.
  - Then an = 6'b111111 and seg = 7'b1111111 for that digit slot.
  - blank_en is sampled live, not snapshotted.
- Frame timing:
  - Frame length is 6*SCAN_DIV cycles.
  - After reset, the first tick occurs at the SCAN_DIV-th edge (idx becomes 1, showing snapshot zeros).
  - The first wrap occurs at edge 6*SCAN_DIV.
- reset asserted at any point, mid-digit or mid-frame, returns every register to its reset value on the next edge. reset has priority over tick.

Test Plan:
- SCAN_DIV=4, reset held 2 cycles then released → an=111111, seg=1111111, dp=1 for edges 1-3 after release; at edge 4 an=111101, seg=1000000 (digit 1 shows snapshot 0).
- hour=0x12, minute=0x34, second=0x56 held; run to first wrap (edge 24) → frame_done=1 for one cycle, an=111110, seg=0000010 (6); next ticks give seg=0010010 (5), then 0011001 (4) with dp=0 on digit 2.
- Change second from 0x56 to 0x57 while idx=2 → digits 3-5 keep the old snapshot; the new value appears only from the next wrap, and dp stays 1 on digits 2 and 4 for that frame.
- hour=0x09, blank_en=1 → when idx=5, an=111111 and seg=1111111; with blank_en=0 → an=011111, seg=1000000.
- minute=0x3A (invalid ones nibble) → at idx=2, an=111011 and seg=1111111.
- Assert reset for one cycle while idx=3 and the prescaler is mid-count → next edge shows all outputs at reset values, and the first tick follows SCAN_DIV edges after release.
